// File: rtl/conv_result_fifo_pkg.sv
// conv_result_fifo_pkg: shared defaults and the wrap-aware pointer increment
// used by the convolution result FIFO.
package conv_result_fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 10;

  // Advance a pointer by one and wrap from depth-1 back to 0.
  // Works for any depth, including depths that are not a power of two.
  function automatic int ptr_inc(input int ptr, input int depth);
    int nxt;
    if (ptr >= depth - 32'sd1) begin
      nxt = 32'sd0;
    end else begin
      nxt = ptr + 32'sd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/conv_result_fifo_mem.sv
// conv_result_fifo_mem: DEPTH x DATA_W storage with one synchronous write
// port and one registered read port. The storage array is never reset; only
// the read register has a synchronous clear so data_out starts at zero.
module conv_result_fifo_mem
  import conv_result_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [PTR_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              rd_clr_i,
  input  logic [PTR_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port: store the accepted word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: clear on reset, load on read enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (rd_clr_i) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/conv_result_fifo.sv
// conv_result_fifo: result buffer between the MAC/accumulate pipeline and the
// downstream consumer. Pointers, occupancy, status flags and the optional
// sticky error flags live here; storage is in conv_result_fifo_mem.
// Optional feature macro: RESULT_FIFO_ERR_EN (sticky overflow/underflow).
module conv_result_fifo
  import conv_result_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AFULL_TH = 8,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;

  logic empty_s, full_s, afull_s;
  logic push_ok_s, pop_ok_s;
  logic wr_en_s, rd_en_s;

  // Flags come straight from the registered count, so they describe the
  // state after the last edge and acceptance uses start-of-cycle values.
  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign full_s  = (count_q == CNT_W'(DEPTH));
  assign afull_s = (count_q >= CNT_W'(AFULL_TH));

  assign push_ok_s = push & ~full_s;
  assign pop_ok_s  = pop & ~empty_s;

  // Flush and reset suppress any memory access in the same cycle.
  assign wr_en_s = push_ok_s & ~flush & ~rst;
  assign rd_en_s = pop_ok_s & ~flush & ~rst;

  // Next-state for pointers, occupancy and the read strobe.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d    = {PTR_W{1'b0}};
      rd_ptr_d    = {PTR_W{1'b0}};
      count_d     = {CNT_W{1'b0}};
      out_valid_d = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = PTR_W'(ptr_inc(int'(wr_ptr_q), DEPTH));
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = PTR_W'(ptr_inc(int'(rd_ptr_q), DEPTH));
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {{(CNT_W-1){1'b0}}, push_ok_s}
                        - {{(CNT_W-1){1'b0}}, pop_ok_s};
      out_valid_d = pop_ok_s;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  conv_result_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (rd_en_s),
    .rd_clr_i  (rst),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

`ifdef RESULT_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; a clear request wins over a same-cycle set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      overflow_d  = overflow_q | (push & full_s);
      underflow_d = underflow_q | (pop & empty_s);
    end
  end

  // Error flag registers, cleared only by reset or err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

  assign out_valid   = out_valid_q;
  assign count       = count_q;
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = afull_s;

endmodule

// File: tb/tb_conv_result_fifo.sv
// tb_conv_result_fifo: directed self-checking bench for conv_result_fifo.
// Instance a uses default parameters (16-bit, 10 deep, afull at 8);
// instance b uses 32-bit, 5 deep, afull at 4.
module tb_conv_result_fifo;

`ifdef RESULT_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // instance a signals
  logic        a_flush, a_push, a_pop, a_err_clr;
  logic [15:0] a_din, a_dout;
  logic        a_ov, a_empty, a_full, a_afull, a_ovf, a_udf;
  logic [3:0]  a_cnt;

  // instance b signals
  logic        b_flush, b_push, b_pop, b_err_clr;
  logic [31:0] b_din, b_dout;
  logic        b_ov, b_empty, b_full, b_afull, b_ovf, b_udf;
  logic [2:0]  b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  conv_result_fifo dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .push(a_push), .data_in(a_din),
    .pop(a_pop), .data_out(a_dout), .out_valid(a_ov), .empty(a_empty),
    .full(a_full), .almost_full(a_afull), .count(a_cnt), .overflow(a_ovf),
    .underflow(a_udf), .err_clr(a_err_clr)
  );

  conv_result_fifo #(.DATA_W(32), .DEPTH(5), .AFULL_TH(4)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .push(b_push), .data_in(b_din),
    .pop(b_pop), .data_out(b_dout), .out_valid(b_ov), .empty(b_empty),
    .full(b_full), .almost_full(b_afull), .count(b_cnt), .overflow(b_ovf),
    .underflow(b_udf), .err_clr(b_err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_status(input string tag, input int cnt, input logic e,
                              input logic f, input logic af);
    chk({tag, "_count"}, 64'(a_cnt), 64'(cnt));
    chk({tag, "_empty"}, 64'(a_empty), 64'(e));
    chk({tag, "_full"},  64'(a_full),  64'(f));
    chk({tag, "_afull"}, 64'(a_afull), 64'(af));
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_err_clr = 1'b0; a_din = 16'h0000;
    b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_err_clr = 1'b0; b_din = 32'h0;

    // Reset state
    step(); step();
    chk_a_status("rst", 0, 1'b1, 1'b0, 1'b0);
    chk("rst_ov",   64'(a_ov),   64'd0);
    chk("rst_dout", 64'(a_dout), 64'd0);
    chk("rst_ovf",  64'(a_ovf),  64'd0);
    chk("rst_udf",  64'(a_udf),  64'd0);
    chk("rst_b_empty", 64'(b_empty), 64'd1);
    rst = 1'b0;

    // Fill with 1..10; almost_full from the 8th push, full at 10
    for (int i = 1; i <= 10; i++) begin
      a_push = 1'b1; a_din = 16'(i);
      step();
      chk_a_status("fill", i, 1'b0, (i == 10), (i >= 8));
    end
    // 11th push rejected
    a_din = 16'h00EE;
    step();
    chk_a_status("ovfpush", 10, 1'b0, 1'b1, 1'b1);
    chk("ovf_set", 64'(a_ovf), 64'(ERR));
    a_push = 1'b0;

    // Drain in order, each word one cycle after its pop
    for (int i = 1; i <= 10; i++) begin
      a_pop = 1'b1;
      step();
      chk("drain_ov",   64'(a_ov),   64'd1);
      chk("drain_data", 64'(a_dout), 64'(i));
      chk("drain_cnt",  64'(a_cnt),  64'(10 - i));
    end
    a_pop = 1'b0;
    step();
    chk("idle_ov",    64'(a_ov),    64'd0);
    chk("idle_hold",  64'(a_dout),  64'h000A);
    chk("idle_empty", 64'(a_empty), 64'd1);
    // Extra pop at empty
    a_pop = 1'b1;
    step();
    chk("udf_ov",  64'(a_ov),  64'd0);
    chk("udf_cnt", 64'(a_cnt), 64'd0);
    chk("udf_set", 64'(a_udf), 64'(ERR));
    a_pop = 1'b0;

    // Wrap-around: preload 3 then 25 cycles of push+pop at count 3
    for (int k = 0; k < 3; k++) begin
      a_push = 1'b1; a_din = 16'(16'h0100 + k);
      step();
    end
    chk("wrap_pre_cnt", 64'(a_cnt), 64'd3);
    for (int k = 0; k < 25; k++) begin
      a_push = 1'b1; a_pop = 1'b1; a_din = 16'(16'h0103 + k);
      step();
      chk("wrap_ov",   64'(a_ov),   64'd1);
      chk("wrap_data", 64'(a_dout), 64'(16'h0100 + k));
      chk("wrap_cnt",  64'(a_cnt),  64'd3);
    end
    a_pop = 1'b0;

    // Top up to full with 0x200..0x206
    for (int k = 0; k < 7; k++) begin
      a_push = 1'b1; a_din = 16'(16'h0200 + k);
      step();
    end
    chk("topup_full", 64'(a_full), 64'd1);
    // Push+pop at full: pop accepted, push dropped
    a_push = 1'b1; a_pop = 1'b1; a_din = 16'hDEAD;
    step();
    chk("fpp_cnt",  64'(a_cnt),  64'd9);
    chk("fpp_ov",   64'(a_ov),   64'd1);
    chk("fpp_data", 64'(a_dout), 64'h0119);
    chk("fpp_full", 64'(a_full), 64'd0);
    a_push = 1'b0;
    // Remaining words: 0x11A, 0x11B, 0x200..0x206 (0xDEAD never stored)
    for (int k = 0; k < 9; k++) begin
      a_pop = 1'b1;
      step();
      chk("fpp_drain", 64'(a_dout), (k < 2) ? 64'(16'h011A + k) : 64'(16'h0200 + k - 2));
    end
    a_pop = 1'b0;
    chk("fpp_empty", 64'(a_empty), 64'd1);

    // Push+pop at empty: push accepted, no bypass
    a_push = 1'b1; a_pop = 1'b1; a_din = 16'h0055;
    step();
    chk_a_status("epp", 1, 1'b0, 1'b0, 1'b0);
    chk("epp_ov", 64'(a_ov), 64'd0);
    a_push = 1'b0;
    step();
    chk("epp_ov2",  64'(a_ov),   64'd1);
    chk("epp_data", 64'(a_dout), 64'h0055);
    a_pop = 1'b0;

    // Flush at count 6 with a concurrent push
    for (int k = 0; k < 6; k++) begin
      a_push = 1'b1; a_din = 16'(16'h0300 + k);
      step();
    end
    chk("pre_flush_cnt", 64'(a_cnt), 64'd6);
    a_flush = 1'b1; a_push = 1'b1; a_din = 16'h03FF;
    step();
    chk_a_status("flush", 0, 1'b1, 1'b0, 1'b0);
    chk("flush_ov",   64'(a_ov),   64'd0);
    chk("flush_dout", 64'(a_dout), 64'h0055);
    chk("flush_ovf",  64'(a_ovf),  64'(ERR));
    chk("flush_udf",  64'(a_udf),  64'(ERR));
    a_flush = 1'b0; a_din = 16'h00AB;
    step();
    a_push = 1'b0; a_pop = 1'b1;
    step();
    chk("postflush_ov",   64'(a_ov),   64'd1);
    chk("postflush_data", 64'(a_dout), 64'h00AB);
    a_pop = 1'b0;

    // Clear error flags
    a_err_clr = 1'b1;
    step();
    chk("clr_ovf", 64'(a_ovf), 64'd0);
    chk("clr_udf", 64'(a_udf), 64'd0);
    a_err_clr = 1'b0;

    // Reset mid-operation with a pending pop
    a_push = 1'b1; a_din = 16'h0077;
    step();
    a_din = 16'h0078;
    step();
    a_push = 1'b0; a_pop = 1'b1; rst = 1'b1;
    step();
    chk("mrst_ov",   64'(a_ov),   64'd0);
    chk("mrst_cnt",  64'(a_cnt),  64'd0);
    chk("mrst_dout", 64'(a_dout), 64'd0);
    rst = 1'b0; a_pop = 1'b0;

    // Instance b: 32-bit, depth 5, afull at 4
    for (int k = 1; k <= 5; k++) begin
      b_push = 1'b1; b_din = 32'hA5A5_0000 + 32'(k);
      step();
      chk("b_cnt",   64'(b_cnt),   64'(k));
      chk("b_afull", 64'(b_afull), 64'(k >= 4));
      chk("b_full",  64'(b_full),  64'(k == 5));
    end
    b_din = 32'hFFFF_FFFF;
    step();
    chk("b_ovfpush_cnt", 64'(b_cnt), 64'd5);
    chk("b_ovf", 64'(b_ovf), 64'(ERR));
    b_push = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      b_pop = 1'b1;
      step();
      chk("b_data", 64'(b_dout), 64'(32'hA5A5_0000 + 32'(k)));
      chk("b_ov",   64'(b_ov),   64'd1);
    end
    step();
    chk("b_empty", 64'(b_empty), 64'd1);
    chk("b_udf",   64'(b_udf),   64'(ERR));
    b_pop = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
